// File: rtl/emu_sched_pkg.sv
// rtl/emu_sched_pkg.sv - shared types and default widths for the run scheduler
package emu_sched_pkg;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DT_WIDTH   = 32;
  localparam int DEF_TIME_WIDTH = 64;
  localparam int DEF_DEC_WIDTH  = 24;

  // Encoding is visible on the state output port, so values are pinned.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_UNTIL = 2'd2,
    ST_STEP  = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    OP_HALT      = 2'd0,
    OP_RUN       = 2'd1,
    OP_RUN_UNTIL = 2'd2,
    OP_STEP      = 2'd3
  } sched_op_e;

endpackage

// File: rtl/dt_min_tree.sv
// rtl/dt_min_tree.sv - unsigned minimum over a packed vector of timestep requests
module dt_min_tree #(
  parameter int N_REQ    = 4,
  parameter int DT_WIDTH = 32
) (
  input  logic [N_REQ*DT_WIDTH-1:0] dt_i,
  output logic [DT_WIDTH-1:0]       dt_min_o
);

  // Linear reduction: keep the smallest slice seen so far.
  always_comb begin
    dt_min_o = dt_i[DT_WIDTH-1:0];
    for (int i = 1; i < N_REQ; i++) begin
      if (dt_i[i*DT_WIDTH +: DT_WIDTH] < dt_min_o) begin
        dt_min_o = dt_i[i*DT_WIDTH +: DT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/emu_run_sched.sv
// rtl/emu_run_sched.sv - emulation run controller: timestep grant, run/until/step FSM, trace decimation
module emu_run_sched
  import emu_sched_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DT_WIDTH   = DEF_DT_WIDTH,
  parameter int TIME_WIDTH = DEF_TIME_WIDTH,
  parameter int DEC_WIDTH  = DEF_DEC_WIDTH
) (
  input  logic                      emu_clk,
  input  logic                      emu_rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [TIME_WIDTH-1:0]     cmd_arg,
  input  logic [TIME_WIDTH-1:0]     emu_time,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [DEC_WIDTH-1:0]      emu_dec_thr,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic [DT_WIDTH-1:0]       dt_req_stall,
  output logic                      emu_dec_cmp,
  output logic                      done,
  output logic [1:0]                state
);

  // Largest timestep expressed in the time domain, for saturating the distance to target.
  localparam logic [TIME_WIDTH-1:0] DT_MAX_T = TIME_WIDTH'({DT_WIDTH{1'b1}});

  sched_state_e          state_q, state_d;
  logic [TIME_WIDTH-1:0] target_q, target_d;
  logic [TIME_WIDTH-1:0] count_q, count_d;
  logic [DEC_WIDTH-1:0]  dec_cnt_q, dec_cnt_d;

  logic                  cmd_acc;
  logic                  advance;
  logic                  until_hit;
  logic                  step_hit;
  logic                  dec_hit;
  logic [TIME_WIDTH-1:0] until_dist;

  assign cmd_ready  = emu_rst_n;
  assign cmd_acc    = cmd_valid & cmd_ready;
  assign state      = state_q;

  assign until_dist = target_q - emu_time;
  assign until_hit  = (state_q == ST_UNTIL) && (emu_time >= target_q);
  assign step_hit   = (state_q == ST_STEP) && (count_q == '0);

  // Completion and trace strobes are asserted in the cycle the condition holds; reset masks them.
  assign advance     = (emu_dt != '0);
  assign dec_hit     = (dec_cnt_q == emu_dec_thr);
  assign done        = emu_rst_n & (until_hit | step_hit);
  assign emu_dec_cmp = emu_rst_n & advance & dec_hit;

  // Controller's own timestep request; zero on completion so time stops exactly at the target.
  always_comb begin
    dt_req_stall = '0;
    if (emu_rst_n) begin
      case (state_q)
        ST_RUN:   dt_req_stall = '1;
        ST_UNTIL: begin
          if (!until_hit) begin
            dt_req_stall = (until_dist > DT_MAX_T) ? '1 : until_dist[DT_WIDTH-1:0];
          end
        end
        ST_STEP:  dt_req_stall = (count_q != '0) ? '1 : '0;
        default:  dt_req_stall = '0;
      endcase
    end
  end

  // Granted timestep is the minimum over all requesters plus the controller itself.
  dt_min_tree #(
    .N_REQ    (N_REQ + 1),
    .DT_WIDTH (DT_WIDTH)
  ) u_dt_min (
    .dt_i     ({dt_req_stall, dt_req}),
    .dt_min_o (emu_dt)
  );

  // Next-state: an accepted command always wins over completion or step counting.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    count_d   = count_q;
    dec_cnt_d = dec_cnt_q;

    if (advance) begin
      dec_cnt_d = dec_hit ? '0 : dec_cnt_q + DEC_WIDTH'(1);
    end

    if (cmd_acc) begin
      case (sched_op_e'(cmd_op))
        OP_HALT:      state_d = ST_IDLE;
        OP_RUN:       state_d = ST_RUN;
        OP_RUN_UNTIL: begin
          state_d  = ST_UNTIL;
          target_d = cmd_arg;
        end
        OP_STEP:      begin
          state_d = ST_STEP;
          count_d = cmd_arg;
        end
        default:      state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_UNTIL: begin
          if (until_hit) state_d = ST_IDLE;
        end
        ST_STEP: begin
          if (step_hit) begin
            state_d = ST_IDLE;
          end else if (advance) begin
            count_d = count_q - TIME_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge emu_clk) begin
    if (!emu_rst_n) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      count_q   <= '0;
      dec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      count_q   <= count_d;
      dec_cnt_q <= dec_cnt_d;
    end
  end

endmodule

// File: tb/tb_emu_run_sched.sv
// tb/tb_emu_run_sched.sv - scoreboard bench for emu_run_sched
module tb_emu_run_sched;
  import emu_sched_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 64;
  localparam int CW = 24;

  logic            emu_clk = 1'b0;
  logic            emu_rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'd0;
  logic [TW-1:0]   cmd_arg = '0;
  logic [TW-1:0]   emu_time = '0;
  logic [N*DW-1:0] dt_req = '0;
  logic [CW-1:0]   emu_dec_thr = '1;
  logic [DW-1:0]   emu_dt;
  logic [DW-1:0]   dt_req_stall;
  logic            emu_dec_cmp;
  logic            done;
  logic [1:0]      state;

  logic            tm_load = 1'b0;
  logic [TW-1:0]   tm_val = '0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DW-1:0] dt;
    logic          done;
    logic [1:0]    st;
    logic          cmp;
  } exp_t;

  exp_t sbq[$];

  emu_run_sched #(
    .N_REQ(N), .DT_WIDTH(DW), .TIME_WIDTH(TW), .DEC_WIDTH(CW)
  ) dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .emu_time(emu_time), .dt_req(dt_req), .emu_dec_thr(emu_dec_thr),
    .emu_dt(emu_dt), .dt_req_stall(dt_req_stall), .emu_dec_cmp(emu_dec_cmp),
    .done(done), .state(state)
  );

  always #5 emu_clk = ~emu_clk;

  // Time manager model: advance by the granted timestep, or load a preset.
  always @(posedge emu_clk) emu_time <= tm_load ? tm_val : emu_time + TW'(emu_dt);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge emu_clk);
    #1;
  endtask

  task automatic set_all_dt(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) dt_req[i*DW +: DW] = v;
  endtask

  task automatic set_time(input logic [TW-1:0] v);
    tm_val = v;
    tm_load = 1'b1;
    tick();
    tm_load = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [TW-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic dn, input logic [1:0] s, input logic c);
    sbq.push_back('{dt: d, done: dn, st: s, cmp: c});
  endtask

  task automatic test_reset();
    exp_t e;
    logic [TW-1:0] t0;
    set_all_dt(32'd5);
    emu_rst_n = 1'b0;
    tick();
    @(negedge emu_clk);
    checks++;
    if (cmd_ready !== 1'b0 || dt_req_stall !== '0 || emu_dt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b stall=%0h dt=%0h, want 0 0 0", cmd_ready, dt_req_stall, emu_dt);
    end
    checks++;
    if (state !== ST_IDLE || done !== 1'b0 || emu_dec_cmp !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d done=%b cmp=%b, want 0 0 0", state, done, emu_dec_cmp);
    end
    tick();
    emu_rst_n = 1'b1;
    t0 = emu_time;
    for (int k = 0; k < 3; k++) begin
      push('0, 1'b0, ST_IDLE, 1'b0);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle k=%0d: got dt=%0h done=%b state=%0d ready=%b, want dt=%0h done=%b state=%0d ready=1",
                 k, emu_dt, done, state, cmd_ready, e.dt, e.done, e.st);
      end
      tick();
    end
    checks++;
    if (emu_time !== t0) begin
      errors++;
      $display("FAIL idle_time_frozen: got %0d, want %0d", emu_time, t0);
    end
  endtask

  task automatic test_run();
    exp_t e;
    logic [TW-1:0] t0;
    dt_req = {32'd9, 32'd7, 32'd3, 32'd5};
    issue(OP_RUN, '0);
    t0 = emu_time;
    for (int k = 0; k < 6; k++) begin
      push(32'd3, 1'b0, ST_RUN, 1'b0);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st || emu_dec_cmp !== e.cmp) begin
        errors++;
        $display("FAIL run k=%0d: got dt=%0h done=%b state=%0d, want dt=%0h done=%b state=%0d",
                 k, emu_dt, done, state, e.dt, e.done, e.st);
      end
      if (k == 0) begin
        checks++;
        if (dt_req_stall !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL run_stall: got %0h, want ffffffff", dt_req_stall);
        end
      end
      tick();
    end
    checks++;
    if (emu_time !== t0 + 64'd18) begin
      errors++;
      $display("FAIL run_time: got %0d, want %0d", emu_time, t0 + 64'd18);
    end
    issue(OP_HALT, '0);
  endtask

  task automatic test_until();
    exp_t e;
    int exp_dt [5] = '{4, 4, 2, 0, 0};
    logic [4:0] dn_v = 5'b01000;
    set_all_dt(32'd4);
    set_time(64'd90);
    issue(OP_RUN_UNTIL, 64'd100);
    for (int k = 0; k < 5; k++) begin
      push(DW'(exp_dt[k]), dn_v[k], (k < 4) ? ST_UNTIL : ST_IDLE, 1'b0);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st || emu_dec_cmp !== e.cmp) begin
        errors++;
        $display("FAIL until k=%0d: got dt=%0h done=%b state=%0d, want dt=%0h done=%b state=%0d",
                 k, emu_dt, done, state, e.dt, e.done, e.st);
      end
      if (k == 0) begin
        checks++;
        if (dt_req_stall !== 32'd10) begin
          errors++;
          $display("FAIL until_stall: got %0d, want 10", dt_req_stall);
        end
      end
      if (k == 3) begin
        checks++;
        if (emu_time !== 64'd100) begin
          errors++;
          $display("FAIL until_done_time: got %0d, want 100", emu_time);
        end
      end
      tick();
    end
  endtask

  task automatic test_step();
    exp_t e;
    logic [TW-1:0] t0;
    int exp_dt [7] = '{6, 0, 0, 6, 6, 0, 0};
    logic [6:0] stall_v = 7'b0000110;
    logic [6:0] dn_v = 7'b0100000;
    set_all_dt(32'd6);
    issue(OP_STEP, 64'd3);
    t0 = emu_time;
    for (int k = 0; k < 7; k++) begin
      dt_req[2*DW +: DW] = stall_v[k] ? '0 : 32'd6;
      push(DW'(exp_dt[k]), dn_v[k], (k < 6) ? ST_STEP : ST_IDLE, 1'b0);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st || emu_dec_cmp !== e.cmp) begin
        errors++;
        $display("FAIL step k=%0d: got dt=%0h done=%b state=%0d, want dt=%0h done=%b state=%0d",
                 k, emu_dt, done, state, e.dt, e.done, e.st);
      end
      tick();
    end
    checks++;
    if (emu_time !== t0 + 64'd18) begin
      errors++;
      $display("FAIL step_time: got %0d, want %0d", emu_time, t0 + 64'd18);
    end
    issue(OP_STEP, 64'd0);
    for (int k = 0; k < 2; k++) begin
      push('0, (k == 0), (k == 0) ? ST_STEP : ST_IDLE, 1'b0);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st) begin
        errors++;
        $display("FAIL step0 k=%0d: got dt=%0h done=%b state=%0d, want dt=%0h done=%b state=%0d",
                 k, emu_dt, done, state, e.dt, e.done, e.st);
      end
      tick();
    end
  endtask

  task automatic test_until_past();
    exp_t e;
    set_all_dt(32'd5);
    set_time(64'd60);
    issue(OP_RUN_UNTIL, 64'd50);
    for (int k = 0; k < 2; k++) begin
      push('0, (k == 0), (k == 0) ? ST_UNTIL : ST_IDLE, 1'b0);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st) begin
        errors++;
        $display("FAIL until_past k=%0d: got dt=%0h done=%b state=%0d, want dt=%0h done=%b state=%0d",
                 k, emu_dt, done, state, e.dt, e.done, e.st);
      end
      tick();
    end
    checks++;
    if (emu_time !== 64'd60) begin
      errors++;
      $display("FAIL until_past_time: got %0d, want 60", emu_time);
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    logic [DW-1:0] exp_dt [3] = '{32'hFFFF_FFFF, 32'd6, 32'hFFFF_FFFF};
    set_all_dt('1);
    set_time('0);
    issue(OP_RUN_UNTIL, 64'h1_0000_0005);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        cmd_valid = 1'b1;
        cmd_op = OP_RUN;
      end
      push(exp_dt[k], 1'b0, (k < 2) ? ST_UNTIL : ST_RUN, 1'b0);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st || dt_req_stall !== e.dt) begin
        errors++;
        $display("FAIL preempt k=%0d: got dt=%0h stall=%0h done=%b state=%0d, want dt=stall=%0h done=%b state=%0d",
                 k, emu_dt, dt_req_stall, done, state, e.dt, e.done, e.st);
      end
      tick();
      cmd_valid = 1'b0;
    end
    issue(OP_HALT, '0);
  endtask

  task automatic test_halt_at_done();
    exp_t e;
    set_all_dt(32'd5);
    set_time(64'd200);
    issue(OP_RUN_UNTIL, 64'd200);
    for (int k = 0; k < 2; k++) begin
      cmd_valid = (k == 0);
      cmd_op = OP_HALT;
      push('0, (k == 0), (k == 0) ? ST_UNTIL : ST_IDLE, 1'b0);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st) begin
        errors++;
        $display("FAIL halt_at_done k=%0d: got dt=%0h done=%b state=%0d, want dt=%0h done=%b state=%0d",
                 k, emu_dt, done, state, e.dt, e.done, e.st);
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    exp_t e;
    set_all_dt(32'd2);
    issue(OP_RUN_UNTIL, 64'd204);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) emu_rst_n = 1'b0;
      if (k == 3) emu_rst_n = 1'b1;
      push((k < 2) ? 32'd2 : 32'd0, 1'b0, (k < 3) ? ST_UNTIL : ST_IDLE, 1'b0);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st || cmd_ready !== (k != 2)) begin
        errors++;
        $display("FAIL reset_midop k=%0d: got dt=%0h done=%b state=%0d ready=%b, want dt=%0h done=%b state=%0d",
                 k, emu_dt, done, state, cmd_ready, e.dt, e.done, e.st);
      end
      tick();
    end
  endtask

  task automatic test_decim();
    exp_t e;
    int n_adv = 0;
    logic [12:0] adv_v = 13'b1111000111110;
    logic        ec;
    emu_rst_n = 1'b0;
    tick();
    emu_rst_n = 1'b1;
    emu_dec_thr = 24'd2;
    set_all_dt(32'd1);
    for (int k = 0; k < 16; k++) begin
      cmd_valid = (k == 0) || (k == 5) || (k == 8);
      cmd_op = (k == 5) ? OP_HALT : OP_RUN;
      if (k == 13) emu_dec_thr = '0;
      ec = 1'b0;
      if (k >= 13) begin
        ec = 1'b1;
      end else if (adv_v[k]) begin
        ec = ((n_adv % 3) == 2);
        n_adv++;
      end
      push((k >= 13 || adv_v[k]) ? 32'd1 : 32'd0, 1'b0, (k >= 13 || adv_v[k]) ? ST_RUN : ST_IDLE, ec);
      @(negedge emu_clk);
      e = sbq.pop_front();
      checks++;
      if (emu_dt !== e.dt || done !== e.done || state !== e.st || emu_dec_cmp !== e.cmp) begin
        errors++;
        $display("FAIL decim k=%0d: got dt=%0h state=%0d cmp=%b, want dt=%0h state=%0d cmp=%b",
                 k, emu_dt, state, emu_dec_cmp, e.dt, e.st, e.cmp);
      end
      tick();
    end
    cmd_valid = 1'b0;
    issue(OP_HALT, '0);
    emu_dec_thr = '1;
  endtask

  initial begin
    test_reset();
    test_run();
    test_until();
    test_step();
    test_until_past();
    test_preempt();
    test_halt_at_done();
    test_reset_midop();
    test_decim();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
